// File: rtl/vc_demux3_pkg.sv
// Shared constants and helpers for the three-way buffered demultiplexer.
package vc_demux3_pkg;

  // Destination encodings carried on sel.
  localparam logic [1:0] SEL_CH0  = 2'd0;
  localparam logic [1:0] SEL_CH1  = 2'd1;
  localparam logic [1:0] SEL_CH2  = 2'd2;
  localparam logic [1:0] SEL_DROP = 2'd3;

  // Width of the saturating drop counter.
  localparam int unsigned DROP_CNT_W = 8;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] val);
    logic [DROP_CNT_W-1:0] res;
    res = val;
    if (val != {DROP_CNT_W{1'b1}}) begin
      res = val + 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/vc_demux3_entry.sv
// One-entry registered buffer with pipelined replace and scrub-on-dequeue.
// The data register returns to zero whenever the entry drains without a refill,
// so a drained channel never exposes the previous payload.
module vc_demux3_entry
  import vc_demux3_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic               full_q, full_d;
  logic [p_nbits-1:0] msg_q, msg_d;
  logic               do_enq;
  logic               do_deq;

  // Handshake decode; a full entry can still accept if it drains this cycle.
  always_comb begin
    do_deq  = full_q & deq_rdy;
    enq_rdy = ~full_q | deq_rdy;
    do_enq  = enq_val & enq_rdy;
    deq_val = full_q;
    deq_msg = msg_q;
  end

  // Next-state: enqueue wins (refill or replace), plain dequeue scrubs the data.
  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    if (do_enq) begin
      full_d = 1'b1;
      msg_d  = enq_msg;
    end else if (do_deq) begin
      full_d = 1'b0;
      msg_d  = '0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
    end
  end

endmodule

// File: rtl/vc_demux3_buf.sv
// Three-way buffered demultiplexer: steers one val/rdy stream to three
// independently stalling channels (or drops it) based on a per-message sel.
// in_rdy depends only on sel and channel state, never on in_val.
module vc_demux3_buf
  import vc_demux3_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [p_nbits-1:0]    in_msg,
  input  logic [1:0]            sel,
  output logic                  out0_val,
  input  logic                  out0_rdy,
  output logic [p_nbits-1:0]    out0_msg,
  output logic                  out1_val,
  input  logic                  out1_rdy,
  output logic [p_nbits-1:0]    out1_msg,
  output logic                  out2_val,
  input  logic                  out2_rdy,
  output logic [p_nbits-1:0]    out2_msg,
  output logic [DROP_CNT_W-1:0] drop_count
);

  logic                  enq0_val, enq1_val, enq2_val;
  logic                  enq0_rdy, enq1_rdy, enq2_rdy;
  logic                  drop_fire;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Sel decode into per-channel enqueue requests; each entry gates with its own rdy.
  always_comb begin
    enq0_val  = in_val & (sel == SEL_CH0);
    enq1_val  = in_val & (sel == SEL_CH1);
    enq2_val  = in_val & (sel == SEL_CH2);
    drop_fire = in_val & (sel == SEL_DROP);
  end

  // Input ready mux; drops are always accepted.
  always_comb begin
    in_rdy = 1'b1;
    unique case (sel)
      SEL_CH0:  in_rdy = enq0_rdy;
      SEL_CH1:  in_rdy = enq1_rdy;
      SEL_CH2:  in_rdy = enq2_rdy;
      SEL_DROP: in_rdy = 1'b1;
      default:  in_rdy = 1'b1;
    endcase
  end

  // Drop counter next-state, saturating at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_fire) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;

  vc_demux3_entry #(
    .p_nbits (p_nbits)
  ) u_entry0 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq0_val),
    .enq_rdy (enq0_rdy),
    .enq_msg (in_msg),
    .deq_val (out0_val),
    .deq_rdy (out0_rdy),
    .deq_msg (out0_msg)
  );

  vc_demux3_entry #(
    .p_nbits (p_nbits)
  ) u_entry1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq1_val),
    .enq_rdy (enq1_rdy),
    .enq_msg (in_msg),
    .deq_val (out1_val),
    .deq_rdy (out1_rdy),
    .deq_msg (out1_msg)
  );

  vc_demux3_entry #(
    .p_nbits (p_nbits)
  ) u_entry2 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq2_val),
    .enq_rdy (enq2_rdy),
    .enq_msg (in_msg),
    .deq_val (out2_val),
    .deq_rdy (out2_rdy),
    .deq_msg (out2_msg)
  );

endmodule

// File: doc/vc_demux3_buf.md
# vc_demux3_buf

Three-way buffered demultiplexer: accepts one val/rdy input stream and steers each message to one of three output channels chosen by a per-message `sel`. Each output channel has a one-entry registered buffer, so the block decouples the shared source from three independently-stalling sinks. It sits on the fan-out side of the shared datapath, where a selected channel splits back into per-domain streams. A buffer's data register is scrubbed to zero when its entry leaves, so stale data from one transfer is never visible on that channel's output.

## Interface
- `p_nbits`, default 32, message width in bits.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_val`  input  1  input message valid.
- `in_rdy`  output  1  input can accept this cycle.
- `in_msg`  input  p_nbits  input payload.
- `sel`  input  2  destination: 0 → ch0, 1 → ch1, 2 → ch2, 3 → drop; sampled with `in_val`.
- `out0_val`, `out1_val`, `out2_val`  output  1 each  channel holds a message.
- `out0_rdy`, `out1_rdy`, `out2_rdy`  input  1 each  sink accepts this cycle.
- `out0_msg`, `out1_msg`, `out2_msg`  output  p_nbits each  channel payload.
- `drop_count`  output  8  saturating count of messages accepted with `sel`==3.

## Operation
- Per channel k: state `full_k`, register `msg_k`. `outk_val` = `full_k`, `outk_msg` = `msg_k`.
- Dequeue on channel k: `full_k && outk_rdy`.
- Channel k can take new data when `!full_k`, or when it dequeues in the same cycle (pipelined replace).
- `in_rdy`:
  - for `sel` 0–2, equals the selected channel's can-take condition;
  - for `sel`==3, `in_rdy`=1.
- `in_rdy` is combinational from `sel`, the `full_k` flags and the `outk_rdy` inputs. It does not depend on `in_val`.
- Enqueue occurs on `in_val && in_rdy` with `sel`=k. On that edge: `full_k`←1 and `msg_k`←`in_msg`.
- Dequeue with no simultaneous enqueue on channel k: `full_k`←0 and `msg_k`←0 (scrub).
- Dequeue plus enqueue in the same cycle: `full_k` stays 1 and `msg_k`←`in_msg`. There is no scrub cycle.
- Drop: on `in_val && sel==3`, the message is discarded and `drop_count` increments. It saturates at 255 and holds there.
- Unselected channels are unaffected by input activity. All three channels may dequeue in the same cycle.
- A channel holding a message that its sink never accepts stalls only inputs addressed to that channel. Inputs addressed to other channels still proceed.
- Message and `sel` stability while `in_val`=1 and `in_rdy`=0 is the source's responsibility. The block does not check it.

## Timing
- Reset (asynchronous assert, synchronous deassert at the source): all `full_k`=0, all `msg_k`=0, `drop_count`=0.
  - Therefore every `outk_val`=0 and every `outk_msg`=0 during and after reset.
  - `in_rdy` after reset = 1 for any `sel`.
- Reset mid-operation discards all buffered messages immediately. No output `val` stays asserted.
- Latency: a message accepted on edge N appears on `outk_val`/`outk_msg` in cycle N+1. There is no combinational in→out path.
- Throughput: one message per cycle into any single channel, provided its sink holds `rdy`=1.
- Empty: `outk_val`=0 and `outk_msg`=0.
- Full, with sink not ready: `in_rdy`=0 for `sel`=k. `msg_k` holds.

## Structure
- Shared package `vc_demux3_pkg`:
  - constants `SEL_CH0`=2'd0, `SEL_CH1`=2'd1, `SEL_CH2`=2'd2, `SEL_DROP`=2'd3;
  - `DROP_CNT_W`=8.
- Sub-module `vc_demux3_entry`, parameterised by `p_nbits`:
  - one-entry buffer with `enq_val`, `enq_rdy`, `enq_msg`, `deq_val`, `deq_rdy`, `deq_msg`;
  - implements the scrub-on-dequeue rule;
  - instantiated three times.
- The top level contains `sel` decode, `in_rdy` mux and the drop counter.

## Test plan
- Reset with `in_val`=1, `sel`=1, `in_msg`=0xDEADBEEF held → all `outk_val`=0, `outk_msg`=0, `drop_count`=0. After release, `out1_val`=1 and `out1_msg`=0xDEADBEEF one cycle after the first accepting edge.
- Routing: send 0x11/`sel`0, 0x22/`sel`1, 0x33/`sel`2 on consecutive cycles, all sinks `rdy`=1 → each channel shows its value exactly one cycle after its enqueue. Each channel's `msg` returns to 0 the cycle after it is dequeued.
- Backpressure: `out0_rdy`=0, send 0xA then 0xB to ch0 → second cycle `in_rdy`=0, `out0_msg` holds 0xA. Meanwhile 0xC to `sel`2 is accepted. Raise `out0_rdy` → 0xB is accepted the same cycle and appears on `out0_msg` the next cycle, with no gap.
- Streaming: 8 back-to-back messages 1..8 to ch2 with `out2_rdy`=1 → `in_rdy`=1 every cycle, and `out2_msg` sequence 1..8 with `out2_val` continuously 1.
- Drop: 260 messages with `sel`=3 → `in_rdy`=1 throughout, no output `val` asserted, `drop_count` saturates at 255.
- Reset mid-flight: all three channels full and stalled, assert `reset` → all `outk_val`/`outk_msg` go to 0 immediately and remain 0 after release.
